// File: rtl/regfile_uart_dump.sv
// Debug read-out engine: walks x0..x31 through a dedicated register-file read
// port and sends each word as four little-endian 8N1 UART bytes on tx_o.
module regfile_uart_dump #(
  parameter int CLK_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [4:0]  ra_o,
  input  logic [31:0] rd_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t            state, state_n;
  logic [4:0]        reg_idx;
  logic [1:0]        byte_idx;
  logic [3:0]        bit_idx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [31:0]       word;
  logic [7:0]        cur_byte;
  logic              frame_bit;
  logic              bit_end;
  logic              frame_end;
  logic              word_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = bit_end && (bit_idx == 4'd9);
  assign word_end  = frame_end && (byte_idx == 2'd3);

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = word[7:0];
      2'd1:    cur_byte = word[15:8];
      2'd2:    cur_byte = word[23:16];
      default: cur_byte = word[31:24];
    endcase
  end

  // Frame layout: start bit, eight data bits LSB first, stop bit.
  always_comb begin
    case (bit_idx)
      4'd0:    frame_bit = 1'b0;
      4'd1:    frame_bit = cur_byte[0];
      4'd2:    frame_bit = cur_byte[1];
      4'd3:    frame_bit = cur_byte[2];
      4'd4:    frame_bit = cur_byte[3];
      4'd5:    frame_bit = cur_byte[4];
      4'd6:    frame_bit = cur_byte[5];
      4'd7:    frame_bit = cur_byte[6];
      4'd8:    frame_bit = cur_byte[7];
      default: frame_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    tx_o    = 1'b1;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    ra_o    = 5'd0;
    case (state)
      IDLE: begin
        if (start_i) state_n = LOAD;
      end
      LOAD: begin
        busy_o  = 1'b1;
        ra_o    = reg_idx;
        state_n = SEND;
      end
      SEND: begin
        busy_o = 1'b1;
        ra_o   = reg_idx;
        tx_o   = frame_bit;
        if (word_end) state_n = (reg_idx == 5'd31) ? DONE : LOAD;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_idx  <= 5'd0;
      byte_idx <= 2'd0;
      bit_idx  <= 4'd0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          reg_idx  <= 5'd0;
          byte_idx <= 2'd0;
          bit_idx  <= 4'd0;
          baud_cnt <= '0;
        end
        LOAD: begin
          byte_idx <= 2'd0;
          bit_idx  <= 4'd0;
          baud_cnt <= '0;
        end
        SEND: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_idx != 4'd9) begin
              bit_idx <= bit_idx + 4'd1;
            end else begin
              bit_idx <= 4'd0;
              if (byte_idx != 2'd3) begin
                byte_idx <= byte_idx + 2'd1;
              end else begin
                byte_idx <= 2'd0;
                // Index stays at 31 on the final word; IDLE clears it.
                if (reg_idx != 5'd31) reg_idx <= reg_idx + 5'd1;
              end
            end
          end
        end
        default: begin
          byte_idx <= 2'd0;
          bit_idx  <= 4'd0;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Captured word is pure data; x0 is forced to zero regardless of the port.
  always_ff @(posedge clk_i) begin
    if (state == LOAD) word <= (reg_idx == 5'd0) ? 32'd0 : rd_i;
  end

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Directed bench for regfile_uart_dump: register-file model on the debug port,
// UART byte monitor on tx_o, and immediate-assertion checks per step.
module tb_regfile_uart_dump;

  localparam int DIV = 4;
  localparam int DUMP_CYCLES = 32 * (1 + 40 * DIV);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        tx, busy, done;

  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic [7:0]  byte_q [$];
  logic [7:0]  mon_byte;
  int          framing_err = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          p0 = 0;

  regfile_uart_dump #(.CLK_DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ra_o(ra), .rd_i(rd),
    .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rd = rf[ra];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // UART receiver: sample each bit at its centre, CLK_DIV = 4 cycles per bit.
  always begin
    @(negedge clk);
    if (tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(negedge clk);
        mon_byte[k] = tx;
      end
      repeat (DIV) @(negedge clk);
      if (tx !== 1'b1) framing_err++;
      byte_q.push_back(mon_byte);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h0101_0101;
    rf[1]  = 32'h1234_5678;
    rf[31] = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
  endtask

  // Runs one dump; s1/s2 are cycles for extra start pulses, wr a cycle for core writes.
  task automatic run_dump(input int s1, input int s2, input int wr);
    int  c;
    logic seen;
    byte_q.delete();
    framing_err = 0;
    done_cnt = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    p0 = cyc;
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ra", ra, 0);
    chk("load_tx", tx, 1);
    @(posedge clk);
    #1;
    chk("first_start_bit", tx, 0);
    for (c = 2; c < DUMP_CYCLES + 200 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        chk("done_latency", cyc - p0, DUMP_CYCLES);
        chk("done_busy", busy, 0);
        chk("done_tx", tx, 1);
      end
      start = (c == s1 || c == s2);
      if (c == wr) begin
        chk("write_window_ra", ra, 10);
        rf[20] = 32'hA5A5_A5A5;
        rf[3]  = 32'h3333_3333;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    repeat (200) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("byte_count", byte_q.size(), 128);
    chk("framing", framing_err, 0);
    chk("idle_after_busy", busy, 0);
    if (byte_q.size() == 128)
      for (int r = 0; r < 32; r++)
        for (int b = 0; b < 4; b++)
          chk($sformatf("x%0d_byte%0d", r, b), byte_q[r*4 + b], (exp_rf[r] >> (8*b)) & 32'hFF);
  endtask

  initial begin
    preload();

    // Reset, then idle.
    repeat (3) @(negedge clk);
    chk("rst_outputs", {tx, busy, done, ra}, {1'b1, 1'b0, 1'b0, 5'd0});
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", {tx, busy, done, ra}, {1'b1, 1'b0, 1'b0, 5'd0});
    end

    // Plain dump.
    run_dump(-1, -1, -1);

    // x0 masking combined with starts while busy.
    rf[0] = 32'hFFFF_FFFF;
    run_dump(10, 3000, -1);

    // Reset mid-frame: data bit 1 of x5 byte 2 (0x05 -> bit value 0).
    byte_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (894) @(posedge clk);
    #2;
    chk("pre_rst_ra", ra, 5);
    chk("pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ra", ra, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_done_after_rst", done_cnt, 0);
    run_dump(-1, -1, -1);

    // Core writes while x10 is on the wire.
    rf[0] = 32'd0;
    preload();
    exp_rf[20] = 32'hA5A5_A5A5;
    run_dump(-1, -1, 1650);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_uart_dump.md
# regfile_uart_dump

Debug read-out engine for the RV32I integer register file. On request it walks registers x0..x31 through one combinational read port and serialises each 32-bit value as four 8N1 UART bytes on a single TX pin. It gives a lab PC a full register snapshot without halting the pipeline. It sits beside the core and uses a dedicated read port, so the core's two architectural read ports and its write port are never touched.

## Interface
- CLK_DIV, 868, clock cycles per UART bit (868 = 100 MHz / 115200); legal range ≥ 2
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  dump request; sampled only in IDLE
- ra_o  out  5  read address to the register file's debug read port
- rd_i  in  32  read data from the debug read port; combinational from ra_o; x0 reads as 0
- tx_o  out  1  UART serial output; idle level 1
- busy_o  out  1  high from the cycle after start is accepted until the dump completes
- done_o  out  1  one-cycle pulse when the last stop bit has finished

## Operation
- Reset values (applied asynchronously): tx_o=1, busy_o=0, done_o=0, ra_o=0, state IDLE, all counters 0.
- State machine:
  - IDLE: tx_o=1, busy_o=0. If start_i=1 at a rising edge, go to LOAD with reg index 0.
  - LOAD (1 cycle): ra_o = reg index, tx_o=1. At the next edge, latch rd_i into a 32-bit word, set byte index 0 and bit index 0, go to SEND.
  - SEND: shifts out the current byte frame. Frame bit 0 is the start bit (0), bits 1..8 are data LSB first, bit 9 is the stop bit (1). Each frame bit is held for exactly CLK_DIV cycles, timed by a baud counter that counts 0..CLK_DIV-1.
    - After the stop bit of byte 0, 1 or 2, the next byte starts with no gap.
    - After the stop bit of byte 3: if reg index < 31, increment it and go to LOAD; if reg index = 31, go to DONE.
  - DONE (1 cycle): done_o=1, busy_o=0, tx_o=1. Then go to IDLE.
- Byte order is little-endian: byte 0 = word[7:0], byte 3 = word[31:24].
- ra_o holds the current reg index through LOAD and SEND and returns to 0 in IDLE.
- Snapshot semantics: each register is captured at its own LOAD edge. The dump is not atomic across registers, and core writes between captures are visible in later registers.
- x0 always transmits as 00 00 00 00. The block masks it itself and does not rely on the register file.
- start_i is ignored while busy_o=1 or during DONE; requests are not queued.
- Reset asserted mid-frame: tx_o returns to 1 immediately, the partial frame is abandoned, and no done_o pulse is generated.
- Counter widths: baud counter is $clog2(CLK_DIV) bits, bit index 4 bits, byte index 2 bits, reg index 5 bits. Counters never wrap outside their stated ranges.

## Timing
- Take P0 as the rising edge where start_i=1 is sampled in IDLE.
- busy_o rises after P0. ra_o=0 during LOAD, which lasts P0..P0+1.
- tx_o falls (start bit of byte 0 of x0) after P0+1.
- One byte frame lasts 10·CLK_DIV cycles. One register lasts 1 + 40·CLK_DIV cycles, including a single idle-high LOAD cycle between registers.
- done_o is high for exactly the cycle following edge P0 + 32·(1+40·CLK_DIV). busy_o falls at that same edge.
- The earliest next accepted start is the edge after done_o.

## Test plan
- Reset then idle: hold rst_i for 3 cycles, release, leave start_i=0 for 100 cycles -> tx_o=1, busy_o=0, done_o=0, ra_o=0 throughout.
- Single dump (CLK_DIV=4): preload x1=0x12345678, x31=0xDEADBEEF, all others = index·0x01010101; pulse start_i -> UART monitor decodes 128 bytes in order 00 00 00 00, 78 56 34 12, …, EF BE AD DE; done_o pulses exactly 5152 cycles after P0.
- x0 masking: register-file model returns 0xFFFFFFFF for address 0 -> the first four bytes are still 00.
- Start while busy: pulse start_i at cycles 10 and 3000 of a dump -> exactly one dump of 128 bytes and one done_o pulse.
- Mid-operation reset: assert rst_i during a data bit of x5 byte 2 -> tx_o=1 and busy_o=0 asynchronously, no done_o; a new start produces a complete dump beginning at x0.
- Concurrent write: write x20=0xA5A5A5A5 while x10 is being sent -> x20 transmits as A5 A5 A5 A5; write x3 during the same window -> the x3 bytes keep the old value.
